// File: rtl/sccb_init_seq_pkg.sv
// Shared definitions for the SCCB camera init-table sequencer: FSM encoding,
// table entry tags and the default camera device address.
package sccb_init_seq_pkg;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_WR_REQ  = 4'd3,
        S_WR_WAIT = 4'd4,
        S_RD_REQ  = 4'd5,
        S_RD_WAIT = 4'd6,
        S_DELAY   = 4'd7,
        S_NEXT    = 4'd8,
        S_FINISH  = 4'd9
    } state_t;

    localparam logic [15:0] END_MARKER      = 16'hFFFF;
    localparam logic [7:0]  DELAY_TAG       = 8'hF0;
    localparam logic [6:0]  DEFAULT_IP_ADDR = 7'h21;

    // A delay entry carries DELAY_TAG in the sub-address byte; FFFF is never a delay.
    function automatic logic is_delay(input logic [15:0] entry);
        return (entry[15:8] == DELAY_TAG) && (entry != END_MARKER);
    endfunction

endpackage

// File: rtl/sccb_init_rom.sv
// Init table storage: TABLE_DEPTH x 16 entries, synchronous read with one
// cycle of latency and a write port used to load the table.
module sccb_init_rom #(
    parameter int TABLE_DEPTH = 256,
    parameter int IDX_W       = $clog2(TABLE_DEPTH)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd_addr,
    output logic [15:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [15:0]      wr_data
);

    logic [15:0] r_mem [TABLE_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
        rd_data <= r_mem[rd_addr];
    end

endmodule

// File: rtl/sccb_init_seq.sv
// Walks the init table on go, issuing SCCB writes (optionally read-back verified)
// and delays until the end marker, the last entry, or a bus timeout.
module sccb_init_seq
    import sccb_init_seq_pkg::*;
#(
    parameter logic [6:0] IP_ADDR        = DEFAULT_IP_ADDR,
    parameter int         TABLE_DEPTH    = 256,
    parameter int         IDX_W          = $clog2(TABLE_DEPTH),
    parameter int         TICKS_PER_MS   = 25000,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] NOVERIFY_ADDR  = 8'h12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             verify_en,
    output logic             busy,
    output logic             seq_done,
    output logic             error,
    output logic [7:0]       err_count,
    output logic [IDX_W-1:0] cur_index,
    output logic             sccb_start,
    output logic             sccb_rw,
    output logic [6:0]       sccb_ip_addr,
    output logic [7:0]       sccb_sub_addr,
    output logic [7:0]       sccb_data_in,
    input  logic [7:0]       sccb_data_out,
    input  logic             sccb_done,
    input  logic             tbl_wr_en,
    input  logic [IDX_W-1:0] tbl_wr_addr,
    input  logic [15:0]      tbl_wr_data,
    output state_t           dbg_state
);

    state_t           r_state, w_next_state;
    logic             r_busy, r_seq_done, r_error, r_verify, r_start, r_rw;
    logic [7:0]       r_err_count, r_sub_addr, r_data_in;
    logic [IDX_W-1:0] r_index;
    logic [15:0]      r_entry, w_rom_data;
    logic [31:0]      r_cnt, w_delay_target;
    logic             w_timeout, w_delay_done, w_last, w_do_verify;

    sccb_init_rom #(.TABLE_DEPTH(TABLE_DEPTH), .IDX_W(IDX_W)) u_rom (
        .clk     (clk),
        .rd_addr (r_index),
        .rd_data (w_rom_data),
        .wr_en   (tbl_wr_en),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data)
    );

    // r_cnt is shared: wait-cycle counter in *_WAIT, elapsed ticks in DELAY.
    assign w_delay_target = 32'(r_entry[7:0]) * 32'(TICKS_PER_MS);
    assign w_delay_done   = (r_cnt + 32'd1) >= w_delay_target;
    assign w_timeout      = (r_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign w_last         = (r_index == IDX_W'(TABLE_DEPTH - 1));
    assign w_do_verify    = r_verify && (r_entry[15:8] != NOVERIFY_ADDR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (go) w_next_state = S_FETCH;
            S_FETCH:   w_next_state = S_DECODE;
            S_DECODE: begin
                if (w_rom_data == END_MARKER)  w_next_state = S_FINISH;
                else if (is_delay(w_rom_data)) w_next_state = S_DELAY;
                else                           w_next_state = S_WR_REQ;
            end
            S_WR_REQ:  w_next_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (sccb_done)      w_next_state = w_do_verify ? S_RD_REQ : S_NEXT;
                else if (w_timeout) w_next_state = S_FINISH;
            end
            S_RD_REQ:  w_next_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (sccb_done)      w_next_state = S_NEXT;
                else if (w_timeout) w_next_state = S_FINISH;
            end
            S_DELAY:   if (w_delay_done) w_next_state = S_NEXT;
            S_NEXT:    w_next_state = w_last ? S_FINISH : S_FETCH;
            S_FINISH:  w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy      <= 1'b0;
            r_seq_done  <= 1'b0;
            r_error     <= 1'b0;
            r_err_count <= 8'd0;
            r_index     <= '0;
            r_verify    <= 1'b0;
            r_entry     <= 16'd0;
            r_cnt       <= 32'd0;
            r_start     <= 1'b0;
            r_rw        <= 1'b0;
            r_sub_addr  <= 8'd0;
            r_data_in   <= 8'd0;
        end else begin
            r_seq_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (go) begin
                        r_busy      <= 1'b1;
                        r_error     <= 1'b0;
                        r_err_count <= 8'd0;
                        r_index     <= '0;
                        r_verify    <= verify_en;
                    end
                end
                S_DECODE: begin
                    r_entry <= w_rom_data;
                    r_cnt   <= 32'd0;
                end
                S_WR_REQ: begin
                    r_start    <= 1'b1;
                    r_rw       <= 1'b0;
                    r_sub_addr <= r_entry[15:8];
                    r_data_in  <= r_entry[7:0];
                    r_cnt      <= 32'd0;
                end
                S_RD_REQ: begin
                    r_start <= 1'b1;
                    r_rw    <= 1'b1;
                    r_cnt   <= 32'd0;
                end
                S_WR_WAIT, S_RD_WAIT: begin
                    // start drops on the same edge that samples done or expires the wait
                    if (sccb_done) begin
                        r_start <= 1'b0;
                        if (r_state == S_RD_WAIT && sccb_data_out != r_entry[7:0]) begin
                            r_error <= 1'b1;
                            if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
                        end
                    end else if (w_timeout) begin
                        r_start <= 1'b0;
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                S_DELAY:  r_cnt <= r_cnt + 32'd1;
                S_NEXT:   if (!w_last) r_index <= r_index + 1'b1;
                S_FINISH: begin
                    r_seq_done <= 1'b1;
                    r_busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy          = r_busy;
    assign seq_done      = r_seq_done;
    assign error         = r_error;
    assign err_count     = r_err_count;
    assign cur_index     = r_index;
    assign sccb_start    = r_start;
    assign sccb_rw       = r_rw;
    assign sccb_ip_addr  = IP_ADDR;
    assign sccb_sub_addr = r_sub_addr;
    assign sccb_data_in  = r_data_in;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_sccb_init_seq.sv
// Bench for sccb_init_seq: an SCCB master model checks each bus transaction
// against a queue of expected {rw, ip, sub, data} pushed when a run is started.
module tb_sccb_init_seq;
  import sccb_init_seq_pkg::*;

  localparam int DEPTH   = 8;
  localparam int IW      = $clog2(DEPTH);
  localparam int TICKS   = 10;
  localparam int TIMEOUT = 100;

  logic          clk, reset, go, verify_en;
  logic          busy, seq_done, error;
  logic [7:0]    err_count;
  logic [IW-1:0] cur_index;
  logic          sccb_start, sccb_rw;
  logic [6:0]    sccb_ip_addr;
  logic [7:0]    sccb_sub_addr, sccb_data_in, sccb_data_out;
  logic          sccb_done;
  logic          tbl_wr_en;
  logic [IW-1:0] tbl_wr_addr;
  logic [15:0]   tbl_wr_data;
  state_t        dbg_state;

  sccb_init_seq #(
    .TABLE_DEPTH(DEPTH), .TICKS_PER_MS(TICKS), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .go(go), .verify_en(verify_en),
    .busy(busy), .seq_done(seq_done), .error(error), .err_count(err_count),
    .cur_index(cur_index), .sccb_start(sccb_start), .sccb_rw(sccb_rw),
    .sccb_ip_addr(sccb_ip_addr), .sccb_sub_addr(sccb_sub_addr),
    .sccb_data_in(sccb_data_in), .sccb_data_out(sccb_data_out), .sccb_done(sccb_done),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (seq_done) done_cnt <= done_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] tbl [DEPTH];
  logic [7:0]  model_regs [256];
  logic [7:0]  rd_corrupt = 8'h00;
  logic        model_mute = 1'b0;
  int          last_done_cyc = 0;
  int          last_gap = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] wr_txn(input logic [7:0] sub, input logic [7:0] data);
    return {1'b0, 7'h21, sub, data};
  endfunction

  function automatic logic [23:0] rd_txn(input logic [7:0] sub);
    return {1'b1, 7'h21, sub, 8'h00};
  endfunction

  // ---------------- SCCB master model ----------------
  initial begin : sccb_model
    logic [23:0] obs;
    logic [23:0] exp;
    int          lat;
    sccb_done = 1'b0;
    sccb_data_out = 8'h00;
    for (int i = 0; i < 256; i++) model_regs[i] = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (!reset && !model_mute && sccb_start) begin
        last_gap = cyc - last_done_cyc;
        obs = {sccb_rw, sccb_ip_addr, sccb_sub_addr, sccb_rw ? 8'h00 : sccb_data_in};
        check("txn_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          check("txn", 32'(obs), 32'(exp));
        end
        if (!sccb_rw) model_regs[sccb_sub_addr] = sccb_data_in;
        lat = $urandom_range(1, 5);
        repeat (lat) @(posedge clk);
        #1;
        sccb_data_out = model_regs[sccb_sub_addr] ^ rd_corrupt;
        sccb_done = 1'b1;
        @(posedge clk); #1;
        sccb_done = 1'b0;
        last_done_cyc = cyc;
        check("start_drop", 32'(sccb_start), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_table();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      tbl_wr_en = 1'b1;
      tbl_wr_addr = IW'(i);
      tbl_wr_data = tbl[i];
    end
    @(negedge clk);
    tbl_wr_en = 1'b0;
  endtask

  task automatic pulse_go(input logic v);
    @(negedge clk);
    go = 1'b1;
    verify_en = v;
    @(negedge clk);
    go = 1'b0;
    verify_en = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(posedge clk); #1;
      cycles++;
      if (seq_done) break;
    end
    check(tag, 32'(seq_done), 32'd1);
  endtask

  task automatic wait_start(input string tag, input int budget);
    int n = 0;
    while (n < budget && !sccb_start) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(sccb_start), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int cycles;
    int d0;
    reset = 1'b1; go = 1'b0; verify_en = 1'b0;
    tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_seq_done", 32'(seq_done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_cur_index", 32'(cur_index), 0);
    check("rst_start", 32'(sccb_start), 0);
    check("rst_rw", 32'(sccb_rw), 0);
    check("rst_ip_addr", 32'(sccb_ip_addr), 32'h21);
    check("rst_sub_addr", 32'(sccb_sub_addr), 0);
    check("rst_data_in", 32'(sccb_data_in), 0);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;

    // A: writes with a 2 ms delay between, verify off
    tbl = '{16'h1280, 16'hF002, 16'h1101, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_table();
    exp_q.push_back(wr_txn(8'h12, 8'h80));
    exp_q.push_back(wr_txn(8'h11, 8'h01));
    d0 = done_cnt;
    last_done_cyc = cyc;
    pulse_go(1'b0);
    check("a_busy", 32'(busy), 1);
    run_until_done("a_seq_done", 400, cycles);
    repeat (3) @(posedge clk);
    #1;
    check("a_delay_gap_ge20", 32'(last_gap >= 20), 1);
    check("a_done_count", 32'(done_cnt - d0), 1);
    check("a_error", 32'(error), 0);
    check("a_busy_end", 32'(busy), 0);
    check("a_end_index", 32'(cur_index), 3);
    check("a_queue_empty", 32'(exp_q.size()), 0);

    // B: verify on, read-back matches; 0x12 is never read
    exp_q.push_back(wr_txn(8'h12, 8'h80));
    exp_q.push_back(wr_txn(8'h11, 8'h01));
    exp_q.push_back(rd_txn(8'h11));
    d0 = done_cnt;
    pulse_go(1'b1);
    run_until_done("b_seq_done", 400, cycles);
    repeat (3) @(posedge clk);
    #1;
    check("b_done_count", 32'(done_cnt - d0), 1);
    check("b_error", 32'(error), 0);
    check("b_err_count", 32'(err_count), 0);
    check("b_queue_empty", 32'(exp_q.size()), 0);

    // C: verify on, read-back returns 0x03 for 0x11
    rd_corrupt = 8'h02;
    exp_q.push_back(wr_txn(8'h12, 8'h80));
    exp_q.push_back(wr_txn(8'h11, 8'h01));
    exp_q.push_back(rd_txn(8'h11));
    d0 = done_cnt;
    pulse_go(1'b1);
    run_until_done("c_seq_done", 400, cycles);
    repeat (3) @(posedge clk);
    #1;
    rd_corrupt = 8'h00;
    check("c_done_count", 32'(done_cnt - d0), 1);
    check("c_error", 32'(error), 1);
    check("c_err_count", 32'(err_count), 1);
    check("c_queue_empty", 32'(exp_q.size()), 0);

    // D: master never answers -> timeout abort
    model_mute = 1'b1;
    tbl = '{16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_table();
    d0 = done_cnt;
    pulse_go(1'b0);
    check("d_error_cleared_on_go", 32'(error), 0);
    check("d_err_count_cleared", 32'(err_count), 0);
    wait_start("d_start_seen", 20);
    run_until_done("d_seq_done", TIMEOUT + 50, cycles);
    check("d_timeout_latency", 32'(cycles >= TIMEOUT && cycles <= TIMEOUT + 3), 1);
    check("d_start_low", 32'(sccb_start), 0);
    check("d_error", 32'(error), 1);
    repeat (3) @(posedge clk);
    #1;
    check("d_done_count", 32'(done_cnt - d0), 1);

    // E: reset while waiting on a write at index 1
    tbl = '{16'hF000, 16'h1280, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    load_table();
    d0 = done_cnt;
    pulse_go(1'b0);
    wait_start("e_start_seen", 20);
    repeat (3) @(posedge clk);
    #1;
    check("e_in_wr_wait", 32'(dbg_state), 32'(S_WR_WAIT));
    reset = 1'b1;
    #1;
    check("e_rst_start", 32'(sccb_start), 0);
    check("e_rst_busy", 32'(busy), 0);
    check("e_rst_index", 32'(cur_index), 0);
    check("e_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("e_rst_error", 32'(error), 0);
    check("e_rst_sub_addr", 32'(sccb_sub_addr), 0);
    check("e_rst_data_in", 32'(sccb_data_in), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("e_no_seq_done", 32'(done_cnt - d0), 0);
    model_mute = 1'b0;
    exp_q.push_back(wr_txn(8'h12, 8'h80));
    pulse_go(1'b0);
    run_until_done("e_restart_done", 200, cycles);
    repeat (3) @(posedge clk);
    #1;
    check("e_done_count", 32'(done_cnt - d0), 1);
    check("e_queue_empty", 32'(exp_q.size()), 0);

    // F: no end marker, go pulsed mid-run during a delay at index 2
    for (int i = 0; i < DEPTH; i++) begin
      logic [7:0] d;
      d = 8'($urandom_range(0, 255));
      tbl[i] = {8'(8'h20 + i), d};
      if (i != 2) exp_q.push_back(wr_txn(8'(8'h20 + i), d));
    end
    tbl[2] = 16'hF005;
    load_table();
    d0 = done_cnt;
    pulse_go(1'b0);
    begin
      int n = 0;
      while (n < 200 && !(cur_index == IW'(2) && dbg_state == S_DELAY)) begin
        @(posedge clk); #1;
        n++;
      end
    end
    check("f_reached_delay", 32'(cur_index), 2);
    repeat (5) @(posedge clk);
    pulse_go(1'b1);
    #1;
    check("f_go_ignored_index", 32'(cur_index), 2);
    check("f_go_ignored_busy", 32'(busy), 1);
    run_until_done("f_seq_done", 600, cycles);
    repeat (3) @(posedge clk);
    #1;
    check("f_end_index", 32'(cur_index), DEPTH - 1);
    check("f_done_count", 32'(done_cnt - d0), 1);
    check("f_error", 32'(error), 0);
    check("f_queue_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sccb_init_seq.md
SCCB_INIT_SEQ -- requirements
Module: sccb_init_seq

Interface
REQ-001 Parameter IP_ADDR, 7'h21, 7-bit camera SCCB device address driven on every transaction.
REQ-002 Parameter TABLE_DEPTH, 256, number of 16-bit init-table entries; IDX_W = clog2(TABLE_DEPTH).
REQ-003 Parameter TICKS_PER_MS, 25000, clk cycles per delay unit.
REQ-004 Parameter TIMEOUT_CYCLES, 65535, maximum cycles waiting for sccb_done per transaction.
REQ-005 Parameter NOVERIFY_ADDR, 8'h12, sub-address excluded from readback verify (self-clearing register).
REQ-006 clk  in  1  single clock; all logic on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 go  in  1  one-cycle pulse; starts table walk from index 0.
REQ-009 verify_en  in  1  sampled on go; 1 = read back and compare each written register.
REQ-010 busy  out  1  high from go acceptance until sequence end.
REQ-011 seq_done  out  1  one-cycle pulse at sequence end (normal or abort).
REQ-012 error  out  1  sticky; set on mismatch or timeout, cleared on next accepted go.
REQ-013 err_count  out  8  saturating mismatch count for current run.
REQ-014 cur_index  out  IDX_W  index of entry being processed.
REQ-015 sccb_start, sccb_rw  out  1 each  transaction request and direction (0 write, 1 read) to SCCB master.
REQ-016 sccb_ip_addr  out  7; sccb_sub_addr, sccb_data_in  out  8 each; sccb_data_out  in  8; sccb_done  in  1.

Function
REQ-017 Entry format {sub_addr[15:8], data[7:0]}; 16'hFFFF = end marker; sub_addr 8'hF0 = delay of data x TICKS_PER_MS cycles, no bus access.
REQ-018 States: IDLE, FETCH, DECODE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT, DELAY, NEXT, FINISH.
REQ-019 IDLE: go accepted -> FETCH, index 0, error/err_count cleared, verify_en latched; go while busy ignored.
REQ-020 FETCH presents index to table; DECODE uses data one cycle later (synchronous read).
REQ-021 DECODE: end marker -> FINISH; delay entry -> DELAY; else -> WR_REQ.
REQ-022 WR_REQ/RD_REQ drive sccb_start=1 with rw, ip_addr, sub_addr, data_in stable; held until sccb_done sampled high.
REQ-023 On the edge sampling sccb_done=1, sccb_start SHALL go 0 (registered) so the master sees start low before restarting.
REQ-024 After write: verify_en=1 and sub_addr != NOVERIFY_ADDR -> RD_REQ; else NEXT.
REQ-025 After read: sccb_data_out != entry data -> error=1, err_count+1 saturating at 255; -> NEXT.
REQ-026 Any wait exceeding TIMEOUT_CYCLES -> error=1, sccb_start=0, FINISH (abort).
REQ-027 DELAY counts data x TICKS_PER_MS cycles; data=0 is zero delay -> NEXT next cycle.
REQ-028 NEXT: index = TABLE_DEPTH-1 -> FINISH (no wrap); else index+1 -> FETCH.
REQ-029 FINISH: seq_done pulse, busy=0, -> IDLE.

Reset
REQ-030 Reset: state IDLE; busy, seq_done, error, sccb_start, sccb_rw = 0; err_count, cur_index, sccb_sub_addr, sccb_data_in = 0; sccb_ip_addr = IP_ADDR.
REQ-031 Reset mid-transaction aborts immediately with no seq_done pulse.

Structure
REQ-032 Shared package: state encoding, END_MARKER 16'hFFFF, DELAY_TAG 8'hF0, default IP_ADDR.
REQ-033 Sub-module sccb_init_rom: synchronous TABLE_DEPTH x 16 table, address in, entry out, one-cycle latency.

Verification
REQ-034 Table {12 80, F0 02, 11 01, FFFF}, verify off, 1 ms = 10 ticks -> two writes (0x12=0x80, 0x11=0x01), >=20-cycle gap, one seq_done, error=0.
REQ-035 Verify on, model returns 0x01 for 0x11 -> write then read 0x11, no read of 0x12, err_count=0.
REQ-036 Verify on, model returns 0x03 for 0x11 -> error=1, err_count=1, sequence completes.
REQ-037 Model never asserts sccb_done -> abort after TIMEOUT_CYCLES, error=1, sccb_start=0, seq_done pulse.
REQ-038 Reset asserted during WR_WAIT -> all outputs at reset values same cycle, no seq_done; next go restarts at index 0.
REQ-039 go pulsed while busy -> ignored, cur_index unaffected; table with no end marker -> FINISH after index TABLE_DEPTH-1.
